// File: rtl/sudoku_input_ctrl.sv
// sudoku_input_ctrl: priority-arbitrates button pulses, keeps cursor and selected
//   digit, and issues single-outstanding write requests to board storage.
// Latency: cursor/digit update on the edge that samples the pulse; wr_req rises on
//   that same edge and holds until wr_ack. Locked cells produce a 1-cycle reject.
// Backpressure: one write in flight; all pulses during WRITE/REJECT are dropped.
//
// Ports:
//   clk, reset (async active-low)
//   up_p/down_p/left_p/right_p/inc_p/enter_p/clear_p : single-cycle button pulses
//   locked   : cursor cell is a clue (combinational from the board)
//   wr_ack   : board storage accepted the pending write
//   cur_row/cur_col/sel_digit : cursor and selected digit
//   wr_req/wr_row/wr_col/wr_data : level write request and its payload
//   busy     : high in WRITE or REJECT
//   reject   : one-cycle pulse on a refused write

module sudoku_input_ctrl #(
  parameter int N = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       up_p,
  input  logic       down_p,
  input  logic       left_p,
  input  logic       right_p,
  input  logic       inc_p,
  input  logic       enter_p,
  input  logic       clear_p,
  input  logic       locked,
  input  logic       wr_ack,
  output logic [3:0] cur_row,
  output logic [3:0] cur_col,
  output logic [3:0] sel_digit,
  output logic       wr_req,
  output logic [3:0] wr_row,
  output logic [3:0] wr_col,
  output logic [3:0] wr_data,
  output logic       busy,
  output logic       reject
);

  localparam logic [3:0] LP_MAX = 4'(N - 1);
  localparam logic [3:0] LP_N   = 4'(N);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_REJECT = 2'd2
  } state_t;

  state_t     r_state;
  logic [3:0] r_row;
  logic [3:0] r_col;
  logic [3:0] r_dig;
  logic       r_wr_req;
  logic [3:0] r_wr_row;
  logic [3:0] r_wr_col;
  logic [3:0] r_wr_data;
  logic       r_busy;
  logic       r_reject;

  // Wrapped neighbours of the cursor and the next digit (N wraps to 1, never 0).
  logic [3:0] w_row_inc;
  logic [3:0] w_row_dec;
  logic [3:0] w_col_inc;
  logic [3:0] w_col_dec;
  logic [3:0] w_dig_inc;
  logic       w_write_cmd;

  assign w_row_inc   = (r_row == LP_MAX) ? 4'd0 : r_row + 4'd1;
  assign w_row_dec   = (r_row == 4'd0) ? LP_MAX : r_row - 4'd1;
  assign w_col_inc   = (r_col == LP_MAX) ? 4'd0 : r_col + 4'd1;
  assign w_col_dec   = (r_col == 4'd0) ? LP_MAX : r_col - 4'd1;
  assign w_dig_inc   = (r_dig == LP_N) ? 4'd1 : r_dig + 4'd1;
  assign w_write_cmd = clear_p | enter_p;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_row     <= 4'd0;
      r_col     <= 4'd0;
      r_dig     <= 4'd1;
      r_wr_req  <= 1'b0;
      r_wr_row  <= 4'd0;
      r_wr_col  <= 4'd0;
      r_wr_data <= 4'd0;
      r_busy    <= 1'b0;
      r_reject  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_write_cmd) begin
            r_busy <= 1'b1;
            if (locked) begin
              r_state  <= S_REJECT;
              r_reject <= 1'b1;
            end else begin
              r_state   <= S_WRITE;
              r_wr_req  <= 1'b1;
              r_wr_row  <= r_row;
              r_wr_col  <= r_col;
              // clear outranks enter, so a simultaneous pair writes 0.
              r_wr_data <= clear_p ? 4'd0 : r_dig;
            end
          end else if (inc_p) begin
            r_dig <= w_dig_inc;
          end else if (up_p) begin
            r_row <= w_row_dec;
          end else if (down_p) begin
            r_row <= w_row_inc;
          end else if (left_p) begin
            r_col <= w_col_dec;
          end else if (right_p) begin
            r_col <= w_col_inc;
          end
        end
        S_WRITE: begin
          if (wr_ack) begin
            r_wr_req <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        S_REJECT: begin
          r_reject <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state  <= S_IDLE;
          r_wr_req <= 1'b0;
          r_busy   <= 1'b0;
          r_reject <= 1'b0;
        end
      endcase
    end
  end

  assign cur_row   = r_row;
  assign cur_col   = r_col;
  assign sel_digit = r_dig;
  assign wr_req    = r_wr_req;
  assign wr_row    = r_wr_row;
  assign wr_col    = r_wr_col;
  assign wr_data   = r_wr_data;
  assign busy      = r_busy;
  assign reject    = r_reject;

endmodule

// File: tb/tb_sudoku_input_ctrl.sv
// tb_sudoku_input_ctrl: directed bench with a write scoreboard for sudoku_input_ctrl.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: wr_ack is driven by the bench at chosen cycles.

module tb_sudoku_input_ctrl;

  localparam int N = 9;

  logic       clk;
  logic       reset;
  logic       up_p, down_p, left_p, right_p, inc_p, enter_p, clear_p;
  logic       locked;
  logic       wr_ack;
  logic [3:0] cur_row, cur_col, sel_digit;
  logic       wr_req;
  logic [3:0] wr_row, wr_col, wr_data;
  logic       busy;
  logic       reject;

  int checks = 0;
  int errors = 0;

  // Reference cursor/digit state and expected write payloads {row,col,data}.
  int         m_row, m_col, m_dig;
  logic [11:0] exp_q[$];

  sudoku_input_ctrl #(.N(N)) dut (
    .clk(clk), .reset(reset),
    .up_p(up_p), .down_p(down_p), .left_p(left_p), .right_p(right_p),
    .inc_p(inc_p), .enter_p(enter_p), .clear_p(clear_p),
    .locked(locked), .wr_ack(wr_ack),
    .cur_row(cur_row), .cur_col(cur_col), .sel_digit(sel_digit),
    .wr_req(wr_req), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .busy(busy), .reject(reject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pos(input string tag);
    chk({tag, "_row"}, 32'(cur_row), 32'(m_row));
    chk({tag, "_col"}, 32'(cur_col), 32'(m_col));
    chk({tag, "_dig"}, 32'(sel_digit), 32'(m_dig));
  endtask

  // kind: 0 up, 1 down, 2 left, 3 right, 4 inc
  task automatic press(input int kind, input bit check);
    case (kind)
      0: begin up_p = 1'b1;    m_row = (m_row + N - 1) % N; end
      1: begin down_p = 1'b1;  m_row = (m_row + 1) % N; end
      2: begin left_p = 1'b1;  m_col = (m_col + N - 1) % N; end
      3: begin right_p = 1'b1; m_col = (m_col + 1) % N; end
      default: begin inc_p = 1'b1; m_dig = (m_dig % N) + 1; end
    endcase
    tick();
    {up_p, down_p, left_p, right_p, inc_p} = '0;
    if (check) chk_pos("move");
  endtask

  // Waits out an in-flight write: checks the payload against the scoreboard on
  // the first request cycle, raises wr_ack in request cycle ack_cyc, and
  // optionally pokes right_p in the first cycle to show it is dropped.
  task automatic serve_write(input string tag, input int ack_cyc, input bit poke);
    int         n;
    logic [11:0] e;
    n = 0;
    e = '0;
    while (wr_req === 1'b1 && n < 20) begin
      if (n == 0) begin
        if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 32'(1), 32'(0));
        else e = exp_q.pop_front();
      end
      chk({tag, "_payload"}, {20'd0, wr_row, wr_col, wr_data}, {20'd0, e});
      chk({tag, "_busy"}, 32'(busy), 32'(1));
      if (n == 0 && poke) right_p = 1'b1;
      n++;
      if (n == ack_cyc) wr_ack = 1'b1;
      tick();
      right_p = 1'b0;
      wr_ack  = 1'b0;
    end
    chk({tag, "_req_cycles"}, 32'(n), 32'(ack_cyc));
    chk({tag, "_busy_after"}, 32'(busy), 32'(0));
    chk_pos({tag, "_pos"});
  endtask

  initial begin
    reset = 1'b0;
    {up_p, down_p, left_p, right_p, inc_p, enter_p, clear_p} = '0;
    locked = 1'b0;
    wr_ack = 1'b0;
    m_row = 0; m_col = 0; m_dig = 1;

    // Reset state.
    #12;
    chk_pos("rst");
    chk("rst_wr_req", 32'(wr_req), 32'(0));
    chk("rst_wr_bus", {20'd0, wr_row, wr_col, wr_data}, 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_reject", 32'(reject), 32'(0));
    reset = 1'b1;
    tick();

    // Column wrap 0..8 -> 0, then row wrap 0 -> 8.
    for (int i = 0; i < 9; i++) press(3, 1'b1);
    chk("col_wrap_zero", 32'(cur_col), 32'(0));
    press(0, 1'b1);
    chk("row_wrap_top", 32'(cur_row), 32'(8));

    // Digit 2..9 then back to 1.
    for (int i = 0; i < 9; i++) press(4, 1'b1);
    chk("dig_wrap_one", 32'(sel_digit), 32'(1));

    // inc beats up in the same cycle.
    inc_p = 1'b1; up_p = 1'b1;
    m_dig = 2;
    tick();
    {inc_p, up_p} = '0;
    chk_pos("inc_over_up");

    // Move to (3,5) with digit 7.
    for (int i = 0; i < 5; i++) press(0, 1'b0);
    for (int i = 0; i < 5; i++) press(3, 1'b0);
    for (int i = 0; i < 5; i++) press(4, 1'b0);
    chk_pos("at_3_5_d7");

    // Unlocked enter, ack in the 5th request cycle, right_p dropped while busy.
    exp_q.push_back({4'd3, 4'd5, 4'd7});
    enter_p = 1'b1;
    tick();
    enter_p = 1'b0;
    chk("enter_req", 32'(wr_req), 32'(1));
    serve_write("wr1", 5, 1'b1);

    // Move to (0,0) and enter on a locked cell.
    for (int i = 0; i < 3; i++) press(0, 1'b0);
    for (int i = 0; i < 5; i++) press(2, 1'b0);
    chk_pos("at_0_0");
    locked = 1'b1;
    enter_p = 1'b1;
    tick();
    enter_p = 1'b0;
    locked = 1'b0;
    chk("rej_pulse", 32'(reject), 32'(1));
    chk("rej_busy", 32'(busy), 32'(1));
    chk("rej_no_req", 32'(wr_req), 32'(0));
    right_p = 1'b1;  // arrives during REJECT, must be dropped
    tick();
    right_p = 1'b0;
    chk("rej_end", 32'(reject), 32'(0));
    chk("rej_busy_end", 32'(busy), 32'(0));
    chk("rej_no_req2", 32'(wr_req), 32'(0));
    chk_pos("rej_pos");

    // clear + enter together: writes 0, ack in the first request cycle.
    exp_q.push_back({4'd0, 4'd0, 4'd0});
    clear_p = 1'b1; enter_p = 1'b1;
    tick();
    {clear_p, enter_p} = '0;
    chk("clr_req", 32'(wr_req), 32'(1));
    serve_write("wr2", 1, 1'b0);

    // Reset mid-write takes effect without a clock edge.
    press(3, 1'b0);
    enter_p = 1'b1;
    tick();
    enter_p = 1'b0;
    chk("pre_rst_req", 32'(wr_req), 32'(1));
    #3;
    reset = 1'b0;
    #1;
    m_row = 0; m_col = 0; m_dig = 1;
    chk("async_req", 32'(wr_req), 32'(0));
    chk("async_busy", 32'(busy), 32'(0));
    chk_pos("async_pos");
    #1;
    reset = 1'b1;
    wr_ack = 1'b1;  // stray ack after reset
    tick();
    wr_ack = 1'b0;
    chk("stray_ack_req", 32'(wr_req), 32'(0));
    chk("stray_ack_busy", 32'(busy), 32'(0));
    chk_pos("stray_ack_pos");
    chk("sb_drained", 32'(exp_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sudoku_input_ctrl.md
# sudoku_input_ctrl

Input controller for the Sudoku board, fed by the single-cycle pulses of the per-button shapers. It arbitrates simultaneous button pulses by fixed priority and keeps the cursor position and the selected digit. It drives a single-outstanding write request/acknowledge handshake into the board storage and rejects writes to locked (clue) cells.

## Interface
- N, default 9: grid dimension; cursor indices run 0..N-1, digits run 1..N (N ≤ 15).
- clk  in  1  system clock, all state changes on rising edge.
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately, release is synchronous to clk.
- up_p, down_p, left_p, right_p  in  1 each  cursor-move pulses, active-high, one cycle wide.
- inc_p  in  1  pulse: advance selected digit.
- enter_p  in  1  pulse: write selected digit into cursor cell.
- clear_p  in  1  pulse: write 0 (empty) into cursor cell.
- locked  in  1  board flag: cell at (cur_row, cur_col) is a clue, not writable; combinational from board, valid every cycle.
- wr_ack  in  1  board storage accepted the write; may arrive 1 or more cycles after wr_req.
- cur_row, cur_col  out  4 each  cursor position.
- sel_digit  out  4  currently selected digit.
- wr_req  out  1  write request, level, held until acknowledged.
- wr_row, wr_col, wr_data  out  4 each  write address/data, stable while wr_req=1.
- busy  out  1  high in WRITE or REJECT.
- reject  out  1  one-cycle pulse: write refused (locked cell).

## Operation
- States: IDLE, WRITE, REJECT. All outputs registered.
- Reset values: state IDLE, cur_row=0, cur_col=0, sel_digit=1, wr_req=0, wr_row=wr_col=wr_data=0, busy=0, reject=0.
- Arbitration in IDLE, fixed priority: clear_p > enter_p > inc_p > up_p > down_p > left_p > right_p. Only the highest asserted pulse acts; the others are discarded.
- Moves: up decrements cur_row, down increments, left decrements cur_col, right increments. Wrap: N-1 → 0 on increment, 0 → N-1 on decrement.
- inc_p: sel_digit increments; N wraps to 1. Value 0 is never held.
- enter_p/clear_p with locked=1 (sampled in the same cycle): go to REJECT; cursor, digit and write outputs unchanged.
- enter_p/clear_p with locked=0: go to WRITE. Latch wr_row=cur_row and wr_col=cur_col. Latch wr_data=sel_digit for enter, 0 for clear. Set wr_req=1.
- WRITE: hold wr_req and the address/data until wr_ack=1 is sampled. On that edge: wr_req←0, state→IDLE.
- REJECT: reject=1 for exactly one cycle, then IDLE.
- All button pulses arriving in WRITE or REJECT are dropped, not queued. The cursor and digit do not change while busy.
- wr_ack sampled while wr_req=0 is ignored.
- Reset asserted mid-WRITE: wr_req drops immediately (async). No write is retried after reset.

## Timing
- Pulse sampled at edge k → cur_row/cur_col/sel_digit show the new value after edge k (0 cycles after the pulse).
- enter_p at edge k (unlocked) → wr_req=1, busy=1 after edge k.
- wr_ack=1 sampled at edge m → wr_req=0, busy=0 after edge m. The earliest next accepted pulse is at edge m+1.
- Minimum write turnaround is 2 cycles (request cycle plus ack cycle). Back-to-back writes need enter pulses at least 2 edges apart.
- Locked enter at edge k → reject=1 and busy=1 during cycle k+1, both 0 after edge k+1. A pulse at edge k+1 is dropped; a pulse at edge k+2 is accepted.

## Test plan
- Reset then 9 right_p pulses → cur_col steps 1..8, then 0. One up_p from row 0 → cur_row=8.
- 9 inc_p pulses from reset → sel_digit 2..9 then 1. Apply inc_p and up_p in the same cycle → only sel_digit changes.
- Move to (3,5), select 7, enter_p with locked=0; wr_ack held low 4 cycles, then high → wr_req high for exactly 5 cycles, with wr_row=3, wr_col=5, wr_data=7 stable. right_p pulsed during the wait is dropped, so cur_col stays 5.
- enter_p with locked=1 at (0,0) → reject high for one cycle, wr_req never asserts, busy high 1 cycle.
- clear_p and enter_p in the same cycle, locked=0 → write with wr_data=0. wr_ack returned in the first request cycle → wr_req high for 1 cycle.
- Assert reset (low) mid-WRITE, between clock edges → wr_req, busy and the cursor go to reset values without a clock edge. After release, a stray wr_ack is ignored.
